mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported data SRAM between the IF-stage instruction fetch and the EXE-stage load/store port.
- Arbitrates per cycle with a combinational grant.
- Issues one SRAM access per cycle.
- Tracks in-flight reads through a tag pipeline so each read response returns to the requester that issued it.
- Sits between the pipeline stages and the SRAM.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; byte-strobe width is DATA_W/8.
- RD_LAT, 1, SRAM read latency in cycles (1..4).
- STARVE_LIMIT, 4, consecutive lost arbitrations after which the instruction port wins (1..15).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  pipeline redirect; kills in-flight instruction reads.
- inst_req  in  1  fetch request.
- inst_addr  in  ADDR_W  fetch address.
- inst_gnt  out  1  fetch request accepted this cycle.
- inst_rvalid  out  1  fetch data valid.
- inst_rdata  out  DATA_W  fetch data.
- data_req  in  1  load/store request.
- data_wen  in  DATA_W/8  byte write strobes; all-zero means a read.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- data_gnt  out  1  data request accepted this cycle.
- data_rvalid  out  1  load data valid.
- data_rdata  out  DATA_W  load data.
- sram_en  out  1  SRAM access enable.
- sram_wen  out  DATA_W/8  SRAM byte write enables.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after the access.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, resetn).
- resetn low:
  - Tag pipeline and starve_cnt clear to 0.
  - inst_rvalid = data_rvalid = 0.
  - inst_gnt, data_gnt, sram_en and sram_wen are forced to 0.
- Reset asserted mid-operation discards all in-flight reads; no response is ever delivered for them.
- Handshake: a transfer occurs when req && gnt in the same cycle.
  - A requester holds req/addr/wdata/wen stable until granted.
  - gnt is combinational from req, flush and starve_cnt.
- Arbitration:
  - Only one requester active: it wins.
  - Both active: data wins, unless starve_cnt == STARVE_LIMIT, in which case inst wins.
  - flush=1 forces inst_gnt=0; data arbitration is unaffected.
- starve_cnt (registered, saturating at STARVE_LIMIT):
  - Increments when inst_req && !inst_gnt && !flush.
  - Clears to 0 on inst_gnt or when inst_req=0.
- SRAM drive:
  - sram_en = inst_gnt | data_gnt.
  - sram_addr comes from the winner.
  - sram_wen = data_gnt ? data_wen : 0.
  - sram_wdata = data_wdata always.
- Tag pipeline: RD_LAT-deep shift register of {valid, owner}.
  - Stage 0 loads valid=1 on an inst grant, or on a data grant with data_wen==0.
  - owner = INST or DATA.
  - Writes push valid=0; a store completes at its grant and has no response.
- Responses:
  - When the last tag stage is valid, the matching *_rvalid is pulsed for 1 cycle with *_rdata = sram_rdata.
  - The non-owner rvalid stays 0.
  - *_rdata is don't-care when its rvalid is 0 (bench must not check it).
  - Response latency is exactly RD_LAT cycles after the grant cycle.
  - There is no response backpressure; requesters always accept.
- flush=1 at a clock edge clears valid in every tag stage whose owner is INST, including the stage being shifted.
  - The INST response due in the flush cycle itself is still delivered combinationally.
  - DATA tags are untouched.
- Throughput: one grant per cycle back-to-back, with up to RD_LAT reads in flight; there is no stall condition.
- Simultaneous flush and data grant: data proceeds normally.

Decomposition:
- Shared package holds:
  - Owner encoding: OWNER_INST=1'b0, OWNER_DATA=1'b1.
  - Tag struct {valid, owner}.
  - Default widths (ADDR_W, DATA_W).
- One sub-module, resp_tag_pipe: the parameterised RD_LAT shift register with push, flush-by-owner and head output.
  - The arbiter top holds the grant logic, starve_cnt and the SRAM mux.

Test Plan:
- Reset release, no requests -> all outputs 0; starve_cnt 0; no rvalid for 10 cycles.
- Lone inst_req, addr 0x80000000, sram_rdata 0x00000013 (RD_LAT=1) -> inst_gnt same cycle; sram_en=1, sram_wen=0; next cycle inst_rvalid=1, inst_rdata=0x13, data_rvalid=0.
- Store data_req, wen=0xFF, addr 0x1000, wdata 0xDEADBEEF -> data_gnt=1; sram_wen=0xFF, sram_wdata=0xDEADBEEF; no data_rvalid afterwards.
- Both requesters held continuously with STARVE_LIMIT=4 -> data granted 4 cycles, inst granted 5th, pattern repeats; each response routed to the correct owner with matching data.
- RD_LAT=2; inst grant at cycle N, data load grant at N+1, flush at N+1 -> no inst_rvalid at N+2; data_rvalid at N+3 with correct data.
- resetn pulled low one cycle after a load grant -> data_rvalid never asserts; gnts and sram_en drop asynchronously while resetn is low.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data SRAM port arbiter: read owner
// encoding, response tag layout and default bus widths.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  // A redirect makes every outstanding fetch useless, so only INST tags die.
  function automatic tag_t kill_inst(tag_t t, logic flush);
    tag_t r;
    r = t;
    if (flush && (t.owner == OWNER_INST)) begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_tag_pipe.sv
// Response tag shift register: remembers who issued each SRAM read so the
// data returning RD_LAT cycles later can be routed back to that requester.
module resp_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   flush,
  input  logic   push_valid,
  input  owner_e push_owner,
  output tag_t   head
);

  tag_t stage_q [RD_LAT];
  tag_t push_tag;

  always_comb begin
    push_tag.valid = push_valid;
    push_tag.owner = push_owner;
  end

  // Every stage shifts each cycle; flush is applied on the way through so a
  // killed fetch can never reach the head.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= kill_inst(push_tag, flush);
      for (int i = 1; i < RD_LAT; i++) begin
        stage_q[i] <= kill_inst(stage_q[i-1], flush);
      end
    end
  end

  assign head = stage_q[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported SRAM between instruction fetch and load/store,
// granting one access per cycle and routing read data back by owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       push_valid;
  owner_e     push_owner;
  tag_t       head;

  // Data normally wins; the instruction port takes over once it has lost
  // STARVE_LIMIT times in a row. Grants are gated by resetn so nothing is
  // issued while the block is held in reset.
  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (resetn) begin
      inst_gnt = inst_req && !flush && (!data_req || (starve_cnt == LIMIT));
      data_gnt = data_req && !inst_gnt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!inst_req || inst_gnt) begin
      starve_cnt <= '0;
    end else if (!flush && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    sram_en    = inst_gnt | data_gnt;
    sram_addr  = inst_gnt ? inst_addr : data_addr;
    sram_wen   = data_gnt ? data_wen : '0;
    sram_wdata = data_wdata;
    push_valid = inst_gnt | (data_gnt & ~|data_wen);
    push_owner = inst_gnt ? OWNER_INST : OWNER_DATA;
  end

  resp_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .push_valid (push_valid),
    .push_owner (push_owner),
    .head       (head)
  );

  always_comb begin
    inst_rvalid = head.valid && (head.owner == OWNER_INST);
    data_rvalid = head.valid && (head.owner == OWNER_DATA);
    inst_rdata  = sram_rdata;
    data_rdata  = sram_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at RD_LAT=1 (a) and one
// at RD_LAT=2 (b), both driven from the same request inputs.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        inst_req = 1'b0;
  logic [63:0] inst_addr = '0;
  logic        data_req = 1'b0;
  logic [7:0]  data_wen = '0;
  logic [63:0] data_addr = '0;
  logic [63:0] data_wdata = '0;
  logic [63:0] sram_rdata = '0;

  logic        inst_gnt_a, inst_rvalid_a, data_gnt_a, data_rvalid_a, sram_en_a;
  logic [63:0] inst_rdata_a, data_rdata_a, sram_addr_a, sram_wdata_a;
  logic [7:0]  sram_wen_a;
  logic        inst_gnt_b, inst_rvalid_b, data_gnt_b, data_rvalid_b, sram_en_b;
  logic [63:0] inst_rdata_b, data_rdata_b, sram_addr_b, sram_wdata_b;
  logic [7:0]  sram_wen_b;

  int checks = 0;
  int errors = 0;
  logic exp_inst;
  logic prev_inst;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RD_LAT(1), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .resetn(resetn), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt_a),
    .inst_rvalid(inst_rvalid_a), .inst_rdata(inst_rdata_a),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt_a),
    .data_rvalid(data_rvalid_a), .data_rdata(data_rdata_a),
    .sram_en(sram_en_a), .sram_wen(sram_wen_a), .sram_addr(sram_addr_a),
    .sram_wdata(sram_wdata_a), .sram_rdata(sram_rdata)
  );

  mem_port_arbiter #(.RD_LAT(2), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .resetn(resetn), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt_b),
    .inst_rvalid(inst_rvalid_b), .inst_rdata(inst_rdata_b),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt_b),
    .data_rvalid(data_rvalid_b), .data_rdata(data_rdata_b),
    .sram_en(sram_en_b), .sram_wen(sram_wen_b), .sram_addr(sram_addr_b),
    .sram_wdata(sram_wdata_b), .sram_rdata(sram_rdata)
  );

  task automatic apply_stimulus(input logic ir, input logic [63:0] ia,
                                input logic dr, input logic [7:0] dw,
                                input logic [63:0] da, input logic [63:0] dd,
                                input logic fl);
    inst_req   = ir;
    inst_addr  = ia;
    data_req   = dr;
    data_wen   = dw;
    data_addr  = da;
    data_wdata = dd;
    flush      = fl;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_sram_en_a", sram_en_a, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    next_cycle();

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_bit("idle_inst_gnt_a", inst_gnt_a, 1'b0);
      check_bit("idle_data_gnt_a", data_gnt_a, 1'b0);
      check_bit("idle_sram_en_a", sram_en_a, 1'b0);
      check_output("idle_sram_wen_a", 64'(sram_wen_a), 64'h0);
      check_bit("idle_inst_rvalid_a", inst_rvalid_a, 1'b0);
      check_bit("idle_data_rvalid_a", data_rvalid_a, 1'b0);
      check_bit("idle_inst_rvalid_b", inst_rvalid_b, 1'b0);
      check_bit("idle_data_rvalid_b", data_rvalid_b, 1'b0);
      next_cycle();
    end

    // lone instruction fetch
    apply_stimulus(1'b1, 64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'h0, 1'b0);
    @(negedge clk);
    check_bit("fetch_inst_gnt", inst_gnt_a, 1'b1);
    check_bit("fetch_data_gnt", data_gnt_a, 1'b0);
    check_bit("fetch_sram_en", sram_en_a, 1'b1);
    check_output("fetch_sram_wen", 64'(sram_wen_a), 64'h0);
    check_output("fetch_sram_addr", sram_addr_a, 64'h8000_0000);
    next_cycle();
    apply_stimulus(1'b0, 64'h0, 1'b0, 8'h00, 64'h0, 64'h0, 1'b0);
    sram_rdata = 64'h13;
    @(negedge clk);
    check_bit("fetch_inst_rvalid_a", inst_rvalid_a, 1'b1);
    check_output("fetch_inst_rdata_a", inst_rdata_a, 64'h13);
    check_bit("fetch_data_rvalid_a", data_rvalid_a, 1'b0);
    check_bit("fetch_inst_rvalid_b_early", inst_rvalid_b, 1'b0);
    next_cycle();
    @(negedge clk);
    check_bit("fetch_inst_rvalid_a_once", inst_rvalid_a, 1'b0);
    check_bit("fetch_inst_rvalid_b", inst_rvalid_b, 1'b1);
    check_output("fetch_inst_rdata_b", inst_rdata_b, 64'h13);
    next_cycle();

    // store: no response expected
    apply_stimulus(1'b0, 64'h0, 1'b1, 8'hFF, 64'h1000, 64'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check_bit("store_data_gnt", data_gnt_a, 1'b1);
    check_bit("store_sram_en", sram_en_a, 1'b1);
    check_output("store_sram_wen", 64'(sram_wen_a), 64'hFF);
    check_output("store_sram_wdata", sram_wdata_a, 64'hDEAD_BEEF);
    check_output("store_sram_addr", sram_addr_a, 64'h1000);
    next_cycle();
    apply_stimulus(1'b0, 64'h0, 1'b0, 8'h00, 64'h0, 64'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("store_no_rvalid_a", data_rvalid_a, 1'b0);
      check_bit("store_no_rvalid_b", data_rvalid_b, 1'b0);
      next_cycle();
    end

    // both ports held: starvation limit gives inst every 5th grant
    apply_stimulus(1'b1, 64'h8000_0040, 1'b1, 8'h00, 64'h2000, 64'h0, 1'b0);
    prev_inst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sram_rdata = 64'h100 + 64'(k);
      exp_inst = ((k % 5) == 4);
      @(negedge clk);
      check_bit("starve_inst_gnt", inst_gnt_a, exp_inst);
      check_bit("starve_data_gnt", data_gnt_a, !exp_inst);
      check_output("starve_sram_addr", sram_addr_a,
                   exp_inst ? 64'h8000_0040 : 64'h2000);
      if (k > 0) begin
        check_bit("starve_inst_rvalid", inst_rvalid_a, prev_inst);
        check_bit("starve_data_rvalid", data_rvalid_a, !prev_inst);
        check_output("starve_rdata", prev_inst ? inst_rdata_a : data_rdata_a,
                     64'h100 + 64'(k));
      end
      prev_inst = exp_inst;
      next_cycle();
    end
    apply_stimulus(1'b0, 64'h0, 1'b0, 8'h00, 64'h0, 64'h0, 1'b0);
    sram_rdata = 64'h10A;
    @(negedge clk);
    check_bit("starve_last_inst_rvalid", inst_rvalid_a, 1'b1);
    check_output("starve_last_inst_rdata", inst_rdata_a, 64'h10A);
    check_bit("starve_last_data_rvalid", data_rvalid_a, 1'b0);
    repeat (3) next_cycle();

    // flush alone blocks a fetch grant
    apply_stimulus(1'b1, 64'h8000_0080, 1'b0, 8'h00, 64'h0, 64'h0, 1'b1);
    @(negedge clk);
    check_bit("flush_blocks_inst_gnt", inst_gnt_a, 1'b0);
    check_bit("flush_blocks_sram_en", sram_en_a, 1'b0);
    next_cycle();
    apply_stimulus(1'b0, 64'h0, 1'b0, 8'h00, 64'h0, 64'h0, 1'b0);
    next_cycle();

    // RD_LAT=2: fetch at N, flush + load at N+1
    apply_stimulus(1'b1, 64'h8000_0100, 1'b0, 8'h00, 64'h0, 64'h0, 1'b0);
    @(negedge clk);
    check_bit("lat2_inst_gnt", inst_gnt_b, 1'b1);
    next_cycle();
    apply_stimulus(1'b0, 64'h0, 1'b1, 8'h00, 64'h3000, 64'h0, 1'b1);
    sram_rdata = 64'h55;
    @(negedge clk);
    check_bit("lat2_flush_data_gnt", data_gnt_b, 1'b1);
    check_bit("lat2_flush_inst_gnt", inst_gnt_b, 1'b0);
    check_bit("lat1_flush_cycle_inst_rvalid", inst_rvalid_a, 1'b1);
    next_cycle();
    apply_stimulus(1'b0, 64'h0, 1'b0, 8'h00, 64'h0, 64'h0, 1'b0);
    @(negedge clk);
    check_bit("lat2_killed_inst_rvalid", inst_rvalid_b, 1'b0);
    check_bit("lat2_early_data_rvalid", data_rvalid_b, 1'b0);
    next_cycle();
    sram_rdata = 64'hCAFE;
    @(negedge clk);
    check_bit("lat2_data_rvalid", data_rvalid_b, 1'b1);
    check_output("lat2_data_rdata", data_rdata_b, 64'hCAFE);
    check_bit("lat2_no_inst_rvalid", inst_rvalid_b, 1'b0);
    repeat (2) next_cycle();

    // reset one cycle after a load grant
    apply_stimulus(1'b0, 64'h0, 1'b1, 8'h00, 64'h4000, 64'h0, 1'b0);
    @(negedge clk);
    check_bit("rst_load_gnt_b", data_gnt_b, 1'b1);
    next_cycle();
    resetn = 1'b0;
    #1;
    check_bit("rst_async_data_gnt_a", data_gnt_a, 1'b0);
    check_bit("rst_async_data_gnt_b", data_gnt_b, 1'b0);
    check_bit("rst_async_sram_en_a", sram_en_a, 1'b0);
    check_bit("rst_async_sram_en_b", sram_en_b, 1'b0);
    @(negedge clk);
    check_bit("rst_no_rvalid_a", data_rvalid_a, 1'b0);
    check_bit("rst_no_rvalid_b", data_rvalid_b, 1'b0);
    apply_stimulus(1'b0, 64'h0, 1'b0, 8'h00, 64'h0, 64'h0, 1'b0);
    next_cycle();
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      check_bit("post_rst_no_rvalid_b", data_rvalid_b, 1'b0);
      check_bit("post_rst_no_rvalid_a", data_rvalid_a, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
